// File: rtl/mbr8_pipe_top_if.sv
// Operand/result handshake bundle for mbr8_pipe_top.
// master = operand feeder and result consumer, slave = the multiplier.
interface mbr8_pipe_top_if #(
   parameter int WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic               sgn;
   logic [WIDTH-1:0]   mx;
   logic [WIDTH-1:0]   my;
   logic [WIDTH-1:0]   mx2;
   logic [WIDTH-1:0]   my2;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;

   modport master (
      output in_valid, sgn, mx, my, out_ready,
      input  in_ready, mx2, my2, out_valid, product
   );

   modport slave (
      input  in_valid, sgn, mx, my, out_ready,
      output in_ready, mx2, my2, out_valid, product
   );
endinterface

// File: rtl/mbr8_pipe_top.sv
// Elastic radix-8 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned per pair.
// Define MBR8_OPERAND_FREEZE_EN to hold data registers across bubbles (only valids shift).
module mbr8_pipe_top #(
   parameter int WIDTH = 32
) (
   input logic            CLK,
   input logic            RST,
   mbr8_pipe_top_if.slave bus
);
   localparam int PW = 2 * WIDTH;        // product width
   localparam int XW = WIDTH + 3;        // wide enough for +-4X of either signedness
   localparam int ND = (WIDTH + 3) / 3;  // ceil((WIDTH+1)/3) Booth digits
   localparam int YW = 3 * ND + 1;       // recoded multiplier incl. implicit 0 LSB
   localparam int NR = ND + 2;           // digit rows + hot-one row + correction row

   // Each row stores {~sign, low bits}; the dropped sign weights sum to this constant.
   function automatic logic [PW-1:0] sign_corr();
      logic [PW-1:0] k;
      logic [PW-1:0] one;
      k   = '0;
      one = {{(PW-1){1'b0}}, 1'b1};
      for (int i = 0; i < ND; i++) k = k - (one << (XW - 1 + 3 * i));
      return k;
   endfunction

   localparam logic [PW-1:0] K_CORR = sign_corr();

   // Handshake: a pair moves when valid & ready are both high on a rising edge.
   // advance = ~out_valid | out_ready; in_ready = advance; every rank shifts on
   // advance (bubbles included) and everything holds otherwise.
   logic adv;
   logic ld_a, ld_b, ld_c, ld_d;

   // rank A: registered operands
   logic             v_a, sgn_a;
   logic [WIDTH-1:0] mx_a, my_a;
   // rank B: multiple of X and recoded digits
   logic                 v_b;
   logic [XW-1:0]        x1_b, x3_b;
   logic [ND-1:0]        neg_b;
   logic [ND-1:0][2:0]   mag_b;
   // rank C: carry-save result
   logic          v_c;
   logic [PW-1:0] sum_c, car_c;
   // rank D: product
   logic          v_d;
   logic [PW-1:0] prod_d;

   assign adv = ~v_d | bus.out_ready;

`ifdef MBR8_OPERAND_FREEZE_EN
   assign ld_a = adv & bus.in_valid;
   assign ld_b = adv & v_a;
   assign ld_c = adv & v_b;
   assign ld_d = adv & v_c;
`else
   assign ld_a = adv;
   assign ld_b = adv;
   assign ld_c = adv;
   assign ld_d = adv;
`endif

   // ---------------- S1: 3X and radix-8 recode ----------------
   logic [XW-1:0]      x1_n, x3_n;
   logic [YW-1:0]      y_ext;
   logic [ND-1:0]      neg_n;
   logic [ND-1:0][2:0] mag_n;

   always_comb begin : s1_comb
      logic [3:0] dig;
      logic [3:0] ndig;
      x1_n  = {{3{sgn_a & mx_a[WIDTH-1]}}, mx_a};
      x3_n  = x1_n + {x1_n[XW-2:0], 1'b0};
      y_ext = {{(YW-WIDTH-1){sgn_a & my_a[WIDTH-1]}}, my_a, 1'b0};
      dig   = '0;
      ndig  = '0;
      neg_n = '0;
      mag_n = '0;
      for (int i = 0; i < ND; i++) begin
         // digit = -4*y[3i+3] + 2*y[3i+2] + y[3i+1] + y[3i]
         dig      = {y_ext[3*i+3], y_ext[3*i+3], y_ext[3*i+2], y_ext[3*i+1]}
                    + {3'b000, y_ext[3*i]};
         ndig     = -dig;
         neg_n[i] = dig[3];
         mag_n[i] = dig[3] ? ndig[2:0] : dig[2:0];
      end
   end

   // ---------------- S2: partial products and CSA tree ----------------
   logic [PW-1:0] t   [NR+2];
   logic [PW-1:0] nxt [NR+2];
   logic [PW-1:0] hot;
   logic [PW-1:0] sum_n, car_n;

   always_comb begin : s2_comb
      logic [XW-1:0] m;
      logic [XW-1:0] pp;
      int n, g, r;
      m   = '0;
      pp  = '0;
      hot = '0;
      for (int k = 0; k < NR + 2; k++) begin
         t[k]   = '0;
         nxt[k] = '0;
      end
      for (int i = 0; i < ND; i++) begin
         case (mag_b[i])
            3'd1:    m = x1_b;
            3'd2:    m = {x1_b[XW-2:0], 1'b0};
            3'd3:    m = x3_b;
            3'd4:    m = {x1_b[XW-3:0], 2'b00};
            default: m = '0;
         endcase
         pp        = neg_b[i] ? ~m : m;
         t[i]      = PW'({~pp[XW-1], pp[XW-2:0]}) << (3 * i);
         hot[3*i]  = neg_b[i];
      end
      t[ND]   = hot;
      t[ND+1] = K_CORR;

      // Wallace-style levels: every full group of three rows becomes two.
      n = NR;
      g = 0;
      r = 0;
      for (int l = 0; l < NR; l++) begin
         if (n > 2) begin
            for (int k = 0; k < NR + 2; k++) nxt[k] = '0;
            for (int k = 0; k < NR; k++) begin
               if (k < n) begin
                  g = k / 3;
                  r = k % 3;
                  if (3 * g + 2 < n) begin
                     if (r == 0) begin
                        nxt[2*g]   = t[k] ^ t[k+1] ^ t[k+2];
                        nxt[2*g+1] = ((t[k] & t[k+1]) | (t[k] & t[k+2]) |
                                      (t[k+1] & t[k+2])) << 1;
                     end
                  end else begin
                     nxt[2*g+r] = t[k];
                  end
               end
            end
            for (int k = 0; k < NR + 2; k++) t[k] = nxt[k];
            n = 2 * (n / 3) + (n % 3);
         end
      end
      sum_n = t[0];
      car_n = t[1];
   end

   // ---------------- registers ----------------
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         v_a <= 1'b0;
         v_b <= 1'b0;
         v_c <= 1'b0;
         v_d <= 1'b0;
      end else if (adv) begin
         v_a <= bus.in_valid;
         v_b <= v_a;
         v_c <= v_b;
         v_d <= v_c;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sgn_a <= 1'b0;
         mx_a  <= '0;
         my_a  <= '0;
      end else if (ld_a) begin
         sgn_a <= bus.sgn;
         mx_a  <= bus.mx;
         my_a  <= bus.my;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         x1_b  <= '0;
         x3_b  <= '0;
         neg_b <= '0;
         mag_b <= '0;
      end else if (ld_b) begin
         x1_b  <= x1_n;
         x3_b  <= x3_n;
         neg_b <= neg_n;
         mag_b <= mag_n;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sum_c <= '0;
         car_c <= '0;
      end else if (ld_c) begin
         sum_c <= sum_n;
         car_c <= car_n;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) prod_d <= '0;
      else if (ld_d) prod_d <= sum_c + car_c;
   end

   assign bus.in_ready  = adv;
   assign bus.mx2       = mx_a;
   assign bus.my2       = my_a;
   assign bus.out_valid = v_d;
   assign bus.product   = prod_d;
endmodule

// File: tb/tb_mbr8_pipe_top.sv
// Bench for mbr8_pipe_top: directed corners, random streaming, back-pressure,
// bubbles and mid-stream reset against an arithmetic reference model.
module tb_mbr8_pipe_top;
   localparam int W  = 32;
   localparam int PW = 64;

   logic CLK;
   logic RST;

   int n_tests   = 0;
   int n_fail    = 0;
   int n_results = 0;

   logic [PW-1:0] exp_q[$];
   logic [W-1:0]  exp_mx2, exp_my2;
   logic          hold_pending;
   logic [PW-1:0] hold_prod, last_prod;

   mbr8_pipe_top_if #(.WIDTH(W)) bus ();

   mbr8_pipe_top #(.WIDTH(W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   // ---------------- clock ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [PW-1:0] ea, eb;
      ea = {{W{s & a[W-1]}}, a};
      eb = {{W{s & b[W-1]}}, b};
      return ea * eb;
   endfunction

   // ---------------- scoreboard / compare process ----------------
   always @(negedge CLK) begin
      if (!RST) begin
         check("rst_out_valid", PW'(bus.out_valid), '0);
         check("rst_product", bus.product, '0);
         check("rst_in_ready", PW'(bus.in_ready), PW'(1));
         check("rst_mx2", PW'(bus.mx2), '0);
         exp_q.delete();
         exp_mx2      = '0;
         exp_my2      = '0;
         hold_pending = 1'b0;
         last_prod    = '0;
      end else begin
         check("in_ready_rule", PW'(bus.in_ready), PW'(!bus.out_valid || bus.out_ready));
         check("mx2", PW'(bus.mx2), PW'(exp_mx2));
         check("my2", PW'(bus.my2), PW'(exp_my2));
         if (hold_pending) begin
            check("stall_product", bus.product, hold_prod);
            check("stall_valid", PW'(bus.out_valid), PW'(1));
         end
`ifdef MBR8_OPERAND_FREEZE_EN
         if (!bus.out_valid) check("freeze_product", bus.product, last_prod);
`endif
         if (bus.out_valid) last_prod = bus.product;
         if (bus.out_valid && bus.out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got 0x%0h expected none at %0t", bus.product, $time);
            end else begin
               check("product", bus.product, exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_mul(bus.sgn, bus.mx, bus.my));
`ifdef MBR8_OPERAND_FREEZE_EN
         if (bus.in_valid && bus.in_ready) begin
`else
         if (bus.in_ready) begin
`endif
            exp_mx2 = bus.mx;
            exp_my2 = bus.my;
         end
         hold_pending = bus.out_valid && !bus.out_ready;
         hold_prod    = bus.product;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         bus.sgn       = 1'($urandom_range(0, 1));
         bus.mx        = $urandom;
         bus.my        = $urandom;
      end
   endtask

   task automatic drive_rand(input logic v, input logic rdy);
      bus.in_valid  = v;
      bus.out_ready = rdy;
      bus.sgn       = 1'($urandom_range(0, 1));
      bus.mx        = $urandom;
      bus.my        = $urandom;
   endtask

   // Assumes an empty pipe; checks the full accept-to-result latency.
   task automatic directed(input string nm, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [PW-1:0] lit);
      @(posedge CLK); #1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.sgn       = s;
      bus.mx        = a;
      bus.my        = b;
      @(posedge CLK); #1;
      drive_rand(1'b0, 1'b1);
      @(posedge CLK); #1;
      check({nm, "_lat1"}, PW'(bus.out_valid), '0);
      @(posedge CLK); #1;
      check({nm, "_lat2"}, PW'(bus.out_valid), '0);
      @(posedge CLK); #1;
      check({nm, "_valid"}, PW'(bus.out_valid), PW'(1));
      check({nm, "_product"}, bus.product, lit);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int r0;
      RST           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.sgn       = 1'b0;
      bus.mx        = '0;
      bus.my        = '0;
      repeat (3) @(posedge CLK);
      #3 RST = 1'b1;

      directed("u_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      idle(5);
      directed("s_ones", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      idle(5);
      directed("s_min_max", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
      idle(5);
      directed("s_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      idle(5);

      // full-rate streaming
      @(posedge CLK); #1;
      drive_rand(1'b1, 1'b1);
      for (int i = 0; i < 10000; i++) begin
         @(posedge CLK); #1;
         if (i >= 3) check("stream_rate", PW'(bus.out_valid), PW'(1));
         drive_rand(1'b1, 1'b1);
      end
      // back-pressure while the pipe is full
      for (int i = 0; i < 5; i++) begin
         drive_rand(1'b1, 1'b0);
         #1 check("bp_in_ready", PW'(bus.in_ready), '0);
         @(posedge CLK); #1;
      end
      for (int i = 0; i < 6; i++) begin
         drive_rand(1'b1, 1'b1);
         @(posedge CLK); #1;
      end
      idle(6);

      // random valid / ready mix
      for (int i = 0; i < 2000; i++) begin
         @(posedge CLK); #1;
         drive_rand(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      idle(6);

      // bubbles: in_valid 1,0,0,1
      r0 = n_results;
      @(posedge CLK); #1; drive_rand(1'b1, 1'b1);
      @(posedge CLK); #1; drive_rand(1'b0, 1'b1);
      @(posedge CLK); #1; drive_rand(1'b0, 1'b1);
      @(posedge CLK); #1; drive_rand(1'b1, 1'b1);
      idle(8);
      check("bubble_count", PW'(n_results - r0), PW'(2));

      // reset with pairs in flight and a result on the output
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         drive_rand(1'b1, 1'b0);
      end
      @(posedge CLK); #3;
      bus.in_valid = 1'b0;
      RST          = 1'b0;
      #1;
      check("mid_rst_out_valid", PW'(bus.out_valid), '0);
      check("mid_rst_product", bus.product, '0);
      check("mid_rst_in_ready", PW'(bus.in_ready), PW'(1));
      repeat (2) @(posedge CLK);
      #3 RST = 1'b1;
      directed("post_rst", 1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
      idle(6);

      check("queue_empty", PW'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mbr8_pipe_top.md
# mbr8_pipe_top

Parametrised, elastic successor to the fixed 32-bit radix-8 Booth multiplier top. It multiplies two WIDTH-bit operands, signed or unsigned per transaction, through a fixed 3-stage pipeline with valid/ready handshakes on both sides. It sits between the operand RAM/stream feeder and the result checker or accumulator. It also echoes the accepted operands so that a bench can align stimulus with results.

## Interface
- WIDTH, 32, operand width; legal range 8..64.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- sgn  in  1  1 = both operands two's complement; 0 = both unsigned.
- mx  in  WIDTH  multiplicand.
- my  in  WIDTH  multiplier.
- mx2  out  WIDTH  stage-1 registered copy of mx.
- my2  out  WIDTH  stage-1 registered copy of my.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  exact product.

## Operation
- Stage 1 (S1):
  - Register mx, my, sgn and valid.
  - Compute 3X = mx + 2·mx at WIDTH+3 bits, extended per sgn.
  - Radix-8 recode my into D = ceil((WIDTH+1)/3) digits in −4..+4.
  - Extend my by one bit per sgn and append the implicit 0 LSB. Pad the top with sign or zero bits to a multiple of 3.
- Stage 2 (S2):
  - Select each partial product from {0, ±X, ±2X, ±3X, ±4X}.
  - Negate as one's complement plus a hot-one bit.
  - Sign-extend using the constant-correction method.
  - Reduce all rows with a CSA tree to sum and carry vectors, 2*WIDTH bits each. Register them with valid.
- Stage 3 (S3): product ← sum + carry, mod 2^(2*WIDTH). Register product and out_valid.
- Arithmetic:
  - The result is exact, with no truncation and no overflow.
  - sgn=1 gives the two's-complement product; sgn=0 gives the unsigned product.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - On advance, every stage shifts by one, including bubbles (valid=0).
  - When advance=0, all stages hold.
  - A pair is accepted iff in_valid & in_ready.
  - A result is consumed iff out_valid & out_ready.
- Throughput is one pair per cycle when out_ready=1. No reordering, no drop, no duplication.
- Simultaneous consume and accept is allowed: the product updates to the next result in the same edge.
- Reset, at any time and mid-stream:
  - All valids clear immediately.
  - mx2, my2 and product clear to 0; in-flight pairs are discarded.
  - out_valid=0 and in_ready=1 while RST is low and after release.

## Timing
- Latency: a pair accepted at edge N gives out_valid=1 with its product after edge N+3, provided advance=1 on edges N+1..N+3.
- Every stall cycle adds one cycle of latency.
- mx2/my2 show the pair from edge N after that edge.
- product, out_valid, mx2 and my2 come directly from registers.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Reset values: out_valid=0, product=0, mx2=0, my2=0, in_ready=1.

## Configuration
- MBR8_OPERAND_FREEZE_EN
  - Defined:
    - Each stage's data registers load only on advance & (incoming valid=1).
    - On bubbles, data holds its last value to cut switching. mx2/my2/product keep the last valid value.
    - Only the valid bits shift on bubbles.
  - Undefined:
    - Data registers load on every advance regardless of valid.
    - mx2/my2 follow mx/my one cycle late, and product carries bubble garbage while out_valid=0.
  - The valid-qualified stream of products is identical in both builds.

## Test plan
All cases use WIDTH=32.
- Unsigned extremes: sgn=0, mx=my=0xFFFFFFFF → product 0xFFFFFFFE00000001 three cycles after accept.
- Signed corners:
  - sgn=1, mx=my=0xFFFFFFFF → 0x0000000000000001.
  - mx=0x80000000, my=0x7FFFFFFF → 0xC000000080000000.
  - mx=my=0x80000000 → 0x4000000000000000.
- Streaming with back-pressure:
  - Drive 10,000 random pairs with random sgn, in_valid=1 and out_ready=1 → one result per cycle after 3-cycle fill, all matching the reference model.
  - Then hold out_ready=0 for 5 cycles → in_ready=0 and product held stable. No pair lost or duplicated after release.
- Bubbles and freeze, with in_valid toggling 1,0,0,1:
  - Defined: product/mx2 hold across bubbles.
  - Undefined: mx2 tracks the inputs.
  - In both builds, exactly two valid products.
- Reset mid-stream: assert RST=0 between edges with 3 pairs in flight → out_valid=0 and product=0 immediately. After release, the first new pair's result appears 3 cycles after its accept, with no stale results.
